// File: rtl/int_ctrl_pkg.sv
// Shared constants and types for the interrupt source controller:
// register word selects, line indices, CTRL bit positions, per-line FSM states.
package int_ctrl_pkg;

    localparam int NUM_LINES = 4;

    // Word selects taken from addr_dm[4:2]
    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_LOAD   = 3'd1;
    localparam logic [2:0] OFF_COUNT  = 3'd2;
    localparam logic [2:0] OFF_STATUS = 3'd3;
    localparam logic [2:0] OFF_SWTRIG = 3'd4;

    localparam int IDX_EXTINT = 0;
    localparam int IDX_OVF    = 1;
    localparam int IDX_INV    = 2;
    localparam int IDX_SYS    = 3;

    localparam int CTRL_TEN     = 0;
    localparam int CTRL_ARL     = 1;
    localparam int CTRL_MEN_LSB = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE   = 2'd1,
        SERVICE = 2'd2
    } line_state_e;

endpackage

// File: rtl/int_line_fsm.sv
// One exception line: takes an enabled pending request, emits a one-cycle
// pulse, then stays in service until a W1C ack arrives.
module int_line_fsm
    import int_ctrl_pkg::*;
(
    input  logic Clk,
    input  logic Rst,
    input  logic pending,
    input  logic mask,
    input  logic ack,
    output logic take,
    output logic pulse,
    output logic insvc
);

    line_state_e state;

    // take is the same-edge clear strobe for the pending bit
    assign take = (state == IDLE) && pending && mask;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
            pulse <= 1'b0;
            insvc <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        state <= PULSE;
                        pulse <= 1'b1;
                        insvc <= 1'b1;
                    end
                end
                PULSE: begin
                    state <= SERVICE;
                    pulse <= 1'b0;
                end
                SERVICE: begin
                    if (ack) begin
                        state <= IDLE;
                        insvc <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    pulse <= 1'b0;
                    insvc <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/int_source_ctrl.sv
// Memory-mapped interrupt source controller: bus registers, edge detectors,
// down-counter timer and one int_line_fsm per ex_int line.
module int_source_ctrl
    import int_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        we_dm,
    input  logic [31:0] addr_dm,
    input  logic [31:0] wd_dm,
    output logic [31:0] rd_dm,
    output logic        hit,
    input  logic [3:0]  irq_req,
    output logic [3:0]  ex_int
);

    logic                 ten, arl, exp_q, tmr_exp;
    logic [NUM_LINES-1:0] men, pend, irq_q, take, insvc, ack, ev, tmr_vec;
    logic [31:0]          load, count;
    logic [2:0]           sel;
    logic                 wr, wr_ctrl, wr_load, wr_status, wr_swtrig;
    logic [1:0]           unused_addr;

    assign unused_addr = addr_dm[1:0];

    assign hit       = (addr_dm[31:5] == BASE_ADDR[31:5]);
    assign sel       = addr_dm[4:2];
    assign wr        = we_dm && hit;
    assign wr_ctrl   = wr && (sel == OFF_CTRL);
    assign wr_load   = wr && (sel == OFF_LOAD);
    assign wr_status = wr && (sel == OFF_STATUS);
    assign wr_swtrig = wr && (sel == OFF_SWTRIG);

    // Expiry is the 1->0 step of a running count
    assign tmr_exp = ten && (count == 32'd1);

    always_comb begin
        tmr_vec             = '0;
        tmr_vec[IDX_EXTINT] = tmr_exp;
        ev  = (irq_req & ~irq_q) | (wr_swtrig ? wd_dm[NUM_LINES-1:0] : '0) | tmr_vec;
        ack = wr_status ? wd_dm[NUM_LINES-1:0] : '0;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            ten   <= 1'b0;
            arl   <= 1'b0;
            men   <= '0;
            load  <= '0;
            count <= '0;
            exp_q <= 1'b0;
            pend  <= '0;
            irq_q <= '0;
        end else begin
            irq_q <= irq_req;
            // An event on the take edge re-arms the line instead of being lost
            pend  <= (pend & ~take) | ev;
            exp_q <= tmr_exp;

            if (exp_q) begin
                if (arl) count <= load;
                else     ten   <= 1'b0;
            end else if (ten && (count != 32'd0)) begin
                count <= count - 32'd1;
            end

            if (wr_ctrl) begin
                ten <= wd_dm[CTRL_TEN];
                arl <= wd_dm[CTRL_ARL];
                men <= wd_dm[CTRL_MEN_LSB +: NUM_LINES];
                if (wd_dm[CTRL_TEN] && !ten) count <= load;
            end

            if (wr_load) load <= wd_dm;
        end
    end

    for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
        int_line_fsm u_line (
            .Clk     (Clk),
            .Rst     (Rst),
            .pending (pend[g]),
            .mask    (men[g]),
            .ack     (ack[g]),
            .take    (take[g]),
            .pulse   (ex_int[g]),
            .insvc   (insvc[g])
        );
    end

    always_comb begin
        rd_dm = '0;
        if (hit) begin
            case (sel)
                OFF_CTRL:   rd_dm = {24'b0, men, 2'b0, arl, ten};
                OFF_LOAD:   rd_dm = load;
                OFF_COUNT:  rd_dm = count;
                OFF_STATUS: rd_dm = {24'b0, insvc, pend};
                default:    rd_dm = '0;
            endcase
        end
    end

endmodule
